// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, register map and helpers for the keypad scan controller
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SCAN     = 2'd1,
        DEBOUNCE = 2'd2,
        RELEASE  = 2'd3
    } scan_state_t;

    localparam int REG_DATA = 0;
    localparam int REG_STAT = 1;
    localparam int REG_CTRL = 2;
    localparam int REG_OVF  = 3;

    localparam int KEY_CODE_W = 4;

    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_CNT_LSB = 4;

    // Several columns closing at once resolve to the lowest-numbered one.
    function automatic logic [1:0] lowest_col(input logic [3:0] pattern);
        if (pattern[0])      return 2'd0;
        else if (pattern[1]) return 2'd1;
        else if (pattern[2]) return 2'd2;
        else                 return 2'd3;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// rtl/keypad_scan_ctrl_if.sv - CPU peripheral port of the keypad scan controller
interface keypad_scan_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              cs;
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;

    modport master (output cs, rd, wr, addr, din, input dout);
    modport slave  (input cs, rd, wr, addr, din, output dout);
endinterface

// File: rtl/keypad_fifo.sv
// rtl/keypad_fifo.sv - key-code queue; a push into a full queue lands when a pop shares the cycle
module keypad_fifo #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_W'(DEPTH));
    assign count     = r_count;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_do_pop  = pop & ~empty & ~flush;
    assign w_do_push = push & (~full | w_do_pop) & ~flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= wdata;
    end
endmodule

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 keypad row scanner, debouncer and bus-mapped code queue
// Optional KEYPAD_IRQ_EN: registered key-available interrupt gated by CTRL irq_en.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int DEB_CNT    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    keypad_scan_ctrl_if.slave   bus,
    input  logic [3:0]          cols,
    output logic [3:0]          rows,
    output logic                irq
);
    localparam int DIV_W  = $clog2(SCAN_DIV);
    localparam int CNT_W  = $clog2(DEB_CNT + 1);
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

    scan_state_t             r_state, w_state_nxt;
    logic [3:0]              r_cols_s1, r_cols_sync;
    logic [DIV_W-1:0]        r_div;
    logic [1:0]              r_row_idx, w_row_idx_nxt;
    logic [3:0]              r_pattern, w_pattern_nxt;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
    logic                    r_enable, r_ovf;
    logic [DATA_W-1:0]       r_dout, w_dout_nxt;
    logic                    w_tick, w_push, w_rd, w_wr, w_pop, w_flush, w_ovf_set;
    logic                    w_ctrl_wr;
    logic [KEY_CODE_W-1:0]   w_code, w_head;
    logic                    w_full, w_empty;
    logic [FCNT_W-1:0]       w_count;
    logic                    w_unused_din;

    assign w_rd         = bus.cs & bus.rd;
    assign w_wr         = bus.cs & bus.wr;
    assign w_ctrl_wr    = w_wr && (bus.addr == ADDR_W'(REG_CTRL));
    assign w_flush      = w_ctrl_wr & bus.din[1];
    assign w_pop        = w_rd && (bus.addr == ADDR_W'(REG_DATA)) && !w_empty;
    assign w_ovf_set    = w_push & w_full & ~w_pop & ~w_flush;
    assign w_code       = {r_row_idx, lowest_col(r_pattern)};
    assign w_tick       = (r_state != IDLE) && (r_div == DIV_W'(SCAN_DIV - 1));
    assign rows         = (r_state == IDLE) ? 4'b0000 : 4'(4'b0001 << r_row_idx);
    assign bus.dout     = r_dout;
    assign w_unused_din = ^bus.din[DATA_W-1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cols_s1   <= '0;
            r_cols_sync <= '0;
        end else begin
            r_cols_s1   <= cols;
            r_cols_sync <= r_cols_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || r_state == IDLE || w_tick) r_div <= '0;
        else                                  r_div <= r_div + DIV_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_row_idx <= '0;
            r_pattern <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_row_idx <= w_row_idx_nxt;
            r_pattern <= w_pattern_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    // r_cnt counts matching samples in DEBOUNCE and quiet samples in RELEASE.
    always_comb begin
        w_state_nxt   = r_state;
        w_row_idx_nxt = r_row_idx;
        w_pattern_nxt = r_pattern;
        w_cnt_nxt     = r_cnt;
        w_push        = 1'b0;
        if (!r_enable) begin
            w_state_nxt   = IDLE;
            w_row_idx_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt   = SCAN;
                    w_row_idx_nxt = '0;
                end
                SCAN: if (w_tick) begin
                    if (r_cols_sync != 4'b0000) begin
                        w_state_nxt   = DEBOUNCE;
                        w_pattern_nxt = r_cols_sync;
                        w_cnt_nxt     = CNT_W'(1);
                    end else begin
                        w_row_idx_nxt = r_row_idx + 2'd1;
                    end
                end
                DEBOUNCE: if (w_tick) begin
                    if (r_cols_sync == r_pattern) begin
                        if (r_cnt >= CNT_W'(DEB_CNT - 1)) begin
                            w_push      = 1'b1;
                            w_state_nxt = RELEASE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_state_nxt = SCAN;
                    end
                end
                RELEASE: if (w_tick) begin
                    if (r_cols_sync == 4'b0000) begin
                        if (r_cnt >= CNT_W'(DEB_CNT - 1)) begin
                            w_state_nxt   = SCAN;
                            w_row_idx_nxt = r_row_idx + 2'd1;
                            w_cnt_nxt     = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        w_dout_nxt = '0;
        if (w_rd) begin
            case (bus.addr)
                ADDR_W'(REG_DATA): begin
                    if (!w_empty) begin
                        w_dout_nxt[KEY_CODE_W]     = 1'b1;
                        w_dout_nxt[KEY_CODE_W-1:0] = w_head;
                    end
                end
                ADDR_W'(REG_STAT): begin
                    w_dout_nxt[STAT_CNT_LSB +: 4] = 4'(w_count);
                    w_dout_nxt[STAT_OVF]          = r_ovf;
                    w_dout_nxt[STAT_FULL]         = w_full;
                    w_dout_nxt[STAT_EMPTY]        = w_empty;
                end
                default: w_dout_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_enable <= 1'b0;
            r_ovf    <= 1'b0;
            r_dout   <= '0;
        end else begin
            r_dout <= w_dout_nxt;
            if (w_ctrl_wr) r_enable <= bus.din[0];
            if (w_ovf_set)
                r_ovf <= 1'b1;
            else if (w_wr && bus.addr == ADDR_W'(REG_OVF) && bus.din[0])
                r_ovf <= 1'b0;
        end
    end

    keypad_fifo #(
        .WIDTH (KEY_CODE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_flush),
        .wdata (w_code),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

`ifdef KEYPAD_IRQ_EN
    logic r_irq_en, r_irq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_irq_en <= bus.din[2];
            r_irq <= r_irq_en & ~w_empty;
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - randomized and directed bench for keypad_scan_ctrl with a behavioural model
module tb_keypad_scan_ctrl;
    localparam int DATA_W = 16, ADDR_W = 4, SCAN_DIV = 4, DEB_CNT = 2, FIFO_DEPTH = 4;
`ifdef KEYPAD_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] cols, rows, raw_cols;
    logic       irq;
    logic       key_on;
    int         key_row, key_col;
    int         checks = 0, errors = 0;

    keypad_scan_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

    keypad_scan_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SCAN_DIV(SCAN_DIV),
        .DEB_CNT(DEB_CNT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus_if), .cols(cols), .rows(rows), .irq(irq)
    );

    always #5 clk = ~clk;

    always_comb cols = raw_cols |
        ((key_on && rows[key_row[1:0]]) ? 4'(4'b0001 << key_col[1:0]) : 4'b0000);

    // Behavioural model: keypad sampled through two delays, FIFO as a queue.
    logic [3:0]  m_s1, m_s2, m_cand;
    bit          m_en, m_irq_en, m_ovf, m_active, m_rel, started;
    int          m_cyc, m_row, m_hits, m_quiet, pushes;
    logic [3:0]  q[$];
    logic [15:0] exp_dout;
    logic [3:0]  exp_rows;
    logic        exp_irq;

    function automatic int low_idx(input logic [3:0] p);
        for (int i = 0; i < 4; i++) if (p[i]) return i;
        return 0;
    endfunction

    function automatic bit push_imminent();
        return m_active && m_en && !m_rel && m_cand != 0 &&
               (m_cyc % SCAN_DIV == SCAN_DIV - 1) && m_s2 == m_cand && m_hits + 1 == DEB_CNT;
    endfunction

    always @(posedge clk) begin : model
        bit rd, wr, pop, push, flush, tick, nirq;
        logic [15:0] nd;
        logic [3:0]  code;
        started = 1'b1;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_cand = 0; m_en = 0; m_irq_en = 0; m_ovf = 0;
            m_active = 0; m_rel = 0; m_cyc = 0; m_row = 0; m_hits = 0; m_quiet = 0;
            q.delete();
            exp_dout = 0; exp_rows = 0; exp_irq = 0;
        end else begin
            rd = bus_if.cs && bus_if.rd;
            wr = bus_if.cs && bus_if.wr;
            nd = 0; pop = 0; push = 0; flush = 0; code = 0;
            if (rd && bus_if.addr == 4'd0 && q.size() > 0) begin
                nd = 16'h0010 + 16'(q[0]);
                pop = 1;
            end else if (rd && bus_if.addr == 4'd1) begin
                nd = (16'(q.size()) << 4) + (16'(m_ovf) << 2) +
                     (16'(q.size() == FIFO_DEPTH) << 1) + 16'(q.size() == 0);
            end
            nirq = IRQ_ON && m_irq_en && q.size() > 0;
            if (!m_active) begin
                if (m_en) begin
                    m_active = 1; m_cyc = 0; m_row = 0; m_cand = 0; m_rel = 0;
                end
            end else if (!m_en) begin
                m_active = 0;
            end else begin
                tick = (m_cyc % SCAN_DIV == SCAN_DIV - 1);
                m_cyc++;
                if (tick) begin
                    if (m_rel) begin
                        if (m_s2 == 0) begin
                            m_quiet++;
                            if (m_quiet == DEB_CNT) begin m_rel = 0; m_row = (m_row + 1) % 4; end
                        end else m_quiet = 0;
                    end else if (m_cand == 0) begin
                        if (m_s2 != 0) begin m_cand = m_s2; m_hits = 1; end
                        else m_row = (m_row + 1) % 4;
                    end else if (m_s2 == m_cand) begin
                        m_hits++;
                        if (m_hits == DEB_CNT) begin
                            push = 1; code = 4'(m_row * 4 + low_idx(m_cand));
                            m_cand = 0; m_rel = 1; m_quiet = 0;
                        end
                    end else m_cand = 0;
                end
            end
            if (wr && bus_if.addr == 4'd2) begin
                m_en = bus_if.din[0]; flush = bus_if.din[1]; m_irq_en = bus_if.din[2];
            end
            if (wr && bus_if.addr == 4'd3 && bus_if.din[0]) m_ovf = 0;
            if (flush) q.delete();
            else begin
                if (pop) void'(q.pop_front());
                if (push) begin
                    if (q.size() < FIFO_DEPTH) q.push_back(code);
                    else m_ovf = 1;
                end
            end
            if (push) pushes++;
            m_s2 = m_s1; m_s1 = cols;
            exp_dout = nd;
            exp_rows = m_active ? 4'(1 << m_row) : 4'd0;
            exp_irq  = nirq;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("rows", 32'(rows), 32'(exp_rows));
            chk("dout", 32'(bus_if.dout), 32'(exp_dout));
            chk("irq", 32'(irq), 32'(exp_irq));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [15:0] d);
        @(posedge clk); #1;
        bus_if.cs = 1; bus_if.rd = 1; bus_if.addr = a;
        @(posedge clk); #1;
        bus_if.cs = 0; bus_if.rd = 0;
        d = bus_if.dout;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [15:0] v);
        @(posedge clk); #1;
        bus_if.cs = 1; bus_if.wr = 1; bus_if.addr = a; bus_if.din = v;
        @(posedge clk); #1;
        bus_if.cs = 0; bus_if.wr = 0;
    endtask

    task automatic wait_release(input string name);
        int n = 0;
        while ((m_rel || m_cand != 0) && n < 300) begin cyc(1); n++; end
        chk(name, 32'(n < 300), 32'd1);
    endtask

    task automatic press_key(input int r, input int c);
        int p0 = pushes;
        int n = 0;
        key_row = r; key_col = c; key_on = 1;
        while (pushes == p0 && n < 300) begin cyc(1); n++; end
        key_on = 0;
        chk("press_accepted", 32'(pushes != p0), 32'd1);
        wait_release("release_done");
    endtask

    task automatic wait_debounce(input int r, input int c);
        int n = 0;
        key_row = r; key_col = c; key_on = 1;
        while (!(m_cand != 0 && !m_rel) && n < 300) begin cyc(1); n++; end
        chk("debounce_reached", 32'(n < 300), 32'd1);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [15:0] d;
        int n;
        bit done;
        raw_cols = 0; key_on = 0; key_row = 0; key_col = 0;
        bus_if.cs = 0; bus_if.rd = 0; bus_if.wr = 0; bus_if.addr = 0; bus_if.din = 0;
        cyc(3);
        rst = 0;
        cyc(1);
        chk("reset_rows", 32'(rows), 32'd0);
        chk("reset_dout", 32'(bus_if.dout), 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);

        bus_write(4'd2, 16'h0001);
        press_key(1, 2);
        bus_read(4'd0, d); chk("t1_data", 32'(d), 32'h0016);
        bus_read(4'd1, d); chk("t1_stat", 32'(d), 32'h0001);

        @(posedge clk); #1; raw_cols = 4'b0001;
        cyc(SCAN_DIV); raw_cols = 4'b0000;
        cyc(3 * SCAN_DIV);
        bus_read(4'd1, d); chk("t2_stat", 32'(d), 32'h0001);

        press_key(0, 0); press_key(1, 1); press_key(2, 2); press_key(3, 3); press_key(0, 3);
        bus_read(4'd1, d); chk("t3_stat", 32'(d), 32'h0046);
        bus_read(4'd0, d); chk("t3_data0", 32'(d), 32'h0010);
        bus_read(4'd0, d); chk("t3_data1", 32'(d), 32'h0015);
        bus_read(4'd0, d); chk("t3_data2", 32'(d), 32'h001A);
        bus_read(4'd0, d); chk("t3_data3", 32'(d), 32'h001F);
        bus_read(4'd0, d); chk("t3_data_empty", 32'(d), 32'h0000);

        bus_write(4'd3, 16'h0001);
        press_key(0, 1); press_key(1, 2); press_key(2, 3); press_key(3, 0);
        key_row = 1; key_col = 0; key_on = 1; n = 0; done = 0; d = 16'hFFFF;
        while (!done && n < 300) begin
            cyc(1); n++;
            if (push_imminent()) begin
                bus_if.cs = 1; bus_if.rd = 1; bus_if.addr = 0;
                cyc(1);
                bus_if.cs = 0; bus_if.rd = 0;
                d = bus_if.dout; done = 1;
            end
        end
        key_on = 0;
        chk("t4_pop_data", 32'(d), 32'h0011);
        wait_release("t4_release");
        bus_read(4'd1, d); chk("t4_stat", 32'(d), 32'h0042);

        wait_debounce(2, 1);
        bus_write(4'd2, 16'h0000);
        cyc(1);
        chk("t5_rows_idle", 32'(rows), 32'd0);
        key_on = 0;
        bus_read(4'd1, d); chk("t5_stat_kept", 32'(d), 32'h0042);
        bus_write(4'd2, 16'h0001);
        cyc(1);
        chk("t5_rows_row0", 32'(rows), 32'd1);
        wait_debounce(1, 3);
        rst = 1; cyc(1); rst = 0; key_on = 0;
        chk("t5_rst_rows", 32'(rows), 32'd0);
        chk("t5_rst_dout", 32'(bus_if.dout), 32'd0);
        chk("t5_rst_irq", 32'(irq), 32'd0);
        bus_read(4'd1, d); chk("t5_rst_stat", 32'(d), 32'h0001);

        bus_write(4'd2, 16'h0005);
        press_key(3, 2);
        chk("t6_irq_set", 32'(irq), 32'(IRQ_ON));
        bus_read(4'd0, d); chk("t6_data", 32'(d), 32'h001E);
        chk("t6_irq_lag", 32'(irq), 32'(IRQ_ON));
        cyc(1);
        chk("t6_irq_clear", 32'(irq), 32'd0);

        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin
                    key_row = $urandom_range(0, 3); key_col = $urandom_range(0, 3);
                    key_on = 1; cyc($urandom_range(1, 40)); key_on = 0;
                    cyc($urandom_range(0, 12));
                end
                4: begin
                    raw_cols = 4'($urandom_range(1, 15));
                    cyc($urandom_range(1, 12)); raw_cols = 0;
                end
                5, 6: begin
                    @(posedge clk); #1;
                    bus_if.cs = ($urandom_range(0, 7) != 0); bus_if.rd = 1;
                    bus_if.addr = 4'($urandom_range(0, 5));
                    cyc($urandom_range(1, 3));
                    bus_if.cs = 0; bus_if.rd = 0;
                end
                7: bus_write(4'd2, 16'(($urandom_range(0, 1) << 2) |
                                      (($urandom_range(0, 5) == 0) << 1) |
                                      ($urandom_range(0, 7) != 0)));
                8: bus_write(4'($urandom_range(3, 5)), 16'($urandom_range(0, 65535)));
                default: begin
                    if ($urandom_range(0, 19) == 0) begin
                        rst = 1; cyc(1); rst = 0;
                        bus_write(4'd2, 16'h0005);
                    end else cyc($urandom_range(1, 8));
                end
            endcase
        end
        cyc(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
